// File: rtl/seq_det_pkg.sv
// Shared constants for the serial pattern detector: FSM state encoding,
// default widths and a helper for sizing the fill counter.
package seq_det_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Bits needed to hold a fill level of 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: clear wins over increment; increment stops at MAX_VAL.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != MAX_VAL)) begin
            value_d = value_q + 1'b1;
        end
    end

    // Counter register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with overlap / non-overlap modes, optional
// lock-after-first-match, soft clear and a saturating match counter.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_FILL   | fewer than PAT_W valid bits collected since last restart
//   ST_ARMED  | history holds PAT_W valid bits; every accepted bit compares
//   ST_LOCKED | a match occurred with lock=1; input ignored until clear
//
// All outputs come straight from flops. The pattern and mode inputs are
// looked at only on the edge that accepts a bit, so a pattern change while
// armed applies to the next accepted bit without restarting the fill.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_valid,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             lock,
    input  logic             clear,
    output logic             match,
    output logic             locked,
    output logic [CNT_W-1:0] count
);

    localparam int              FW        = fill_width(PAT_W);
    localparam logic [FW-1:0]   FILL_FULL = FW'(PAT_W);

    logic [1:0]       state_q,  state_d;
    logic [PAT_W-1:0] hist_q,   hist_d;
    logic [FW-1:0]    fill_q,   fill_d;
    logic             match_q,  match_d;
    logic             locked_q, locked_d;

    logic [PAT_W-1:0] hist_shift;
    logic [FW-1:0]    fill_inc;
    logic             accept;
    logic             hit;

    // Candidate history/fill if the current bit is accepted; the newest bit
    // enters the LSB so pattern[PAT_W-1] lines up with the oldest bit.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], x};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        accept     = x_valid && (state_q != ST_LOCKED) && !clear;
        hit        = accept && (hist_shift == pattern) && (fill_inc == FILL_FULL);
    end

    // Next-state logic: clear beats a bit in the same cycle; a match with
    // overlap=0 restarts the fill so the next match needs PAT_W fresh bits.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        locked_d = locked_q;
        match_d  = 1'b0;
        if (clear) begin
            state_d  = ST_FILL;
            hist_d   = '0;
            fill_d   = '0;
            locked_d = 1'b0;
        end else if (accept) begin
            hist_d  = hist_shift;
            fill_d  = (hit && !overlap) ? '0 : fill_inc;
            match_d = hit;
            if (hit && lock) begin
                state_d  = ST_LOCKED;
                locked_d = 1'b1;
            end else if (fill_d == FILL_FULL) begin
                state_d = ST_ARMED;
            end else begin
                state_d = ST_FILL;
            end
        end
    end

    // Detector registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_FILL;
            hist_q   <= '0;
            fill_q   <= '0;
            match_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            locked_q <= locked_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (hit),
        .value (count)
    );

    assign match  = match_q;
    assign locked = locked_q;

endmodule
